// File: rtl/inst_mem_ctrl_pkg.sv
// Shared definitions for the instruction memory controller: FSM encoding and
// default geometry constants.
package inst_mem_ctrl_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 64;
    localparam int RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/inst_rsp_fifo.sv
// Two-entry in-order response FIFO with synchronous flush; head output reads
// as zero whenever the FIFO is empty.
module inst_rsp_fifo
    import inst_mem_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_slot [0:RSP_FIFO_DEPTH-1];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && (r_count != 2'd2);
    assign w_pop  = pop && (r_count != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else if (flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Payload storage carries no reset; validity comes from r_count alone.
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_slot[r_wptr] <= push_data;
    end

    assign out_valid = (r_count != 2'd0);
    assign out_data  = out_valid ? r_slot[r_rptr] : '0;
    assign count     = r_count;

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: clears memory after reset, then serves
// 1-cycle-latency fetches through a 2-entry response FIFO and accepts program loads.
module inst_mem_ctrl
    import inst_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_exc,
    input  logic                  flush,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_err,
    output logic                  busy
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic                  r_ld_err;

    logic                  w_run;
    logic                  w_busy;
    logic                  w_req_in_range;
    logic                  w_ld_in_range;
    logic [CNT_W-1:0]      w_req_idx;
    logic [CNT_W-1:0]      w_ld_idx;
    logic                  w_req_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_ld_accept;
    logic [DATA_WIDTH:0]   w_push_data;
    logic [DATA_WIDTH:0]   w_fifo_data;
    logic                  w_fifo_valid;
    logic [1:0]            w_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_CLEAR;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_run       = 1'b0;
        case (r_state)
            ST_CLEAR: if (r_cnt == CNT_LAST) w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_busy = 1'b0;
                w_run  = 1'b1;
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_cnt <= '0;
        else if (r_state == ST_CLEAR) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end

    // Address checks are widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    assign w_req_in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign w_ld_in_range  = ({1'b0, ld_addr} < DEPTH_EXT);
    assign w_req_idx      = req_addr[CNT_W-1:0];
    assign w_ld_idx       = ld_addr[CNT_W-1:0];

    assign w_req_ready = w_run && (w_count != 2'd2) && !flush;
    assign w_push      = req_valid && w_req_ready;
    assign w_pop       = w_fifo_valid && rsp_ready;
    assign w_flush     = flush && w_run;
    assign w_ld_accept = ld_valid && w_run;
    assign w_push_data = w_req_in_range ? {1'b0, r_mem[w_req_idx]} : {1'b1, {DATA_WIDTH{1'b0}}};

    // Fetch data is sampled from the pre-edge array, so a same-cycle load is not visible.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR)              r_mem[r_cnt]    <= '0;
        else if (w_ld_accept && w_ld_in_range) r_mem[w_ld_idx] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ld_err <= 1'b0;
        else      r_ld_err <= w_ld_accept && !w_ld_in_range;
    end

    inst_rsp_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_data(w_push_data),
        .pop      (w_pop),
        .flush    (w_flush),
        .out_valid(w_fifo_valid),
        .out_data (w_fifo_data),
        .count    (w_count)
    );

    assign req_ready = w_req_ready;
    assign rsp_valid = w_fifo_valid;
    assign rsp_exc   = w_fifo_data[DATA_WIDTH];
    assign rsp_data  = w_fifo_data[DATA_WIDTH-1:0];
    assign ld_ready  = w_run;
    assign ld_err    = r_ld_err;
    assign busy      = w_busy;

endmodule
